// File: rtl/reg_scoreboard_if.sv
// ---------------------------------------------------------------------------
// reg_scoreboard_if
//
// Purpose:
//   Bundles the decode-side issue port, the writeback retirement port and the
//   scoreboard status outputs of reg_scoreboard into a single interface.
//
// Signals:
//   freeze        pipeline frozen (memory stall); no issue is accepted
//   issue_valid   decode presents an instruction this cycle
//   issue_wb_en   presented instruction writes a register
//   issue_dest    destination register of the presented instruction
//   src1          first source register (rn)
//   src1_valid    src1 is actually read
//   src2          second source register (rm, or rd for stores)
//   two_src       src2 is actually read
//   wb_en         writeback retires a register write this cycle
//   wb_dest       register being retired
//   hazard        stall decode this cycle
//   issue_accept  presented instruction is recorded as issued this cycle
//   pending       bit i set while register i has outstanding writes
//   inflight      total outstanding writes across all registers
//   err           sticky: a writeback retired a register with no writes
//
// Modports:
//   master  the pipeline side (decode + writeback) driving the requests
//   slave   the scoreboard itself
// ---------------------------------------------------------------------------
interface reg_scoreboard_if #(
    parameter int NUM_REGS = 16
);
    logic                freeze;
    logic                issue_valid;
    logic                issue_wb_en;
    logic [3:0]          issue_dest;
    logic [3:0]          src1;
    logic                src1_valid;
    logic [3:0]          src2;
    logic                two_src;
    logic                wb_en;
    logic [3:0]          wb_dest;
    logic                hazard;
    logic                issue_accept;
    logic [NUM_REGS-1:0] pending;
    logic [3:0]          inflight;
    logic                err;

    modport master (
        output freeze, issue_valid, issue_wb_en, issue_dest,
               src1, src1_valid, src2, two_src, wb_en, wb_dest,
        input  hazard, issue_accept, pending, inflight, err
    );

    modport slave (
        input  freeze, issue_valid, issue_wb_en, issue_dest,
               src1, src1_valid, src2, two_src, wb_en, wb_dest,
        output hazard, issue_accept, pending, inflight, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//
// Purpose:
//   Register-dependency scoreboard and stall controller for the decode stage
//   of the 5-stage ARM pipeline. Every register keeps a small counter of
//   writes that have left decode but not yet retired in writeback. Decode is
//   stalled (hazard) when it wants to read a register that still has a write
//   in flight, or when it wants to write a register whose counter is full.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   sb    reg_scoreboard_if.slave carrying the issue port, the writeback
//         retirement port and the hazard/accept/pending/inflight/err outputs
//
// Parameters:
//   NUM_REGS      architectural registers tracked (4-bit register numbers)
//   CNT_W         width of each per-register in-flight counter
//   MAX_INFLIGHT  maximum outstanding writes per register
//   WB_BYPASS     1 = a register retiring this cycle with count 1 reads as
//                 ready (the register file writes before it is read)
// ---------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int NUM_REGS     = 16,
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 3,
    parameter int WB_BYPASS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    reg_scoreboard_if.slave  sb
);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_INFLIGHT);

    // Per-register in-flight counters and their next-state values.
    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];

    logic [3:0]          inflight_q;
    logic [3:0]          inflight_d;
    logic                err_q;
    logic                err_d;

    // One-hot decodes of the retiring and the accepted-issue registers.
    logic [NUM_REGS-1:0] wbHit;
    logic [NUM_REGS-1:0] issueHit;

    logic [NUM_REGS-1:0] regReady;
    logic [NUM_REGS-1:0] regFull;
    logic [NUM_REGS-1:0] pendingVec;

    logic                rawStall;
    logic                capStall;
    logic                hazard;
    logic                accept;
    logic                underflow;

    // Decode the writeback port into a one-hot vector. Kept apart from the
    // issue decode because the issue side depends on the hazard, which in
    // turn depends on this vector.
    always_comb begin
        wbHit = '0;
        if (sb.wb_en) begin
            wbHit = NUM_REGS'(1) << sb.wb_dest;
        end
    end

    // A register is ready to be read when nothing is in flight for it. With
    // the writeback bypass, the last outstanding write retiring this very
    // cycle also counts as ready, since the register file is written in the
    // first half of the cycle and read in the second.
    always_comb begin
        regReady = '0;
        regFull  = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            regFull[r]  = (cnt_q[r] == CNT_MAX);
            regReady[r] = (cnt_q[r] == CNT_ZERO) ||
                          ((WB_BYPASS != 0) && (cnt_q[r] == CNT_ONE) && wbHit[r]);
        end
    end

    // Stall decision. The capacity stall is lifted when the same register is
    // retiring this cycle, because the increment and decrement cancel and the
    // counter never passes MAX_INFLIGHT. The hazard ignores freeze so decode
    // sees a stable stall reason even while the memory stage is stalled.
    always_comb begin
        rawStall = (sb.src1_valid & ~regReady[sb.src1]) |
                   (sb.two_src    & ~regReady[sb.src2]);
        capStall = sb.issue_wb_en & regFull[sb.issue_dest] & ~wbHit[sb.issue_dest];
        hazard   = sb.issue_valid & (rawStall | capStall);
        accept   = sb.issue_valid & ~hazard & ~sb.freeze;
    end

    // Only an accepted instruction that actually writes a register bumps a
    // counter; stalled or frozen instructions leave no trace and are simply
    // re-presented by decode.
    always_comb begin
        issueHit = '0;
        if (accept && sb.issue_wb_en) begin
            issueHit = NUM_REGS'(1) << sb.issue_dest;
        end
    end

    // Counter next state. Issue and retirement of the same register in one
    // cycle cancel out. Retiring a register with a zero count is a protocol
    // error: the count stays at zero and the sticky error flag is raised.
    // The in-flight total is summed from the next-state counters so it moves
    // on the same edge as the counters; it wraps at 4 bits, which the
    // pipeline depth never reaches in normal operation.
    always_comb begin
        underflow  = 1'b0;
        inflight_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issueHit[r] && !wbHit[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (wbHit[r] && !issueHit[r] && (cnt_q[r] != CNT_ZERO)) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
            if (wbHit[r] && (cnt_q[r] == CNT_ZERO)) begin
                underflow = 1'b1;
            end
            inflight_d = inflight_d + 4'(cnt_d[r]);
        end
        err_d = err_q | underflow;
    end

    // State registers. Reset wins over any issue or retirement presented in
    // the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= CNT_ZERO;
            end
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // Pending view is taken straight from the counter registers, so it shows
    // an issue or retirement one cycle after it happens.
    always_comb begin
        pendingVec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pendingVec[r] = (cnt_q[r] != CNT_ZERO);
        end
    end

    assign sb.hazard       = hazard;
    assign sb.issue_accept = accept;
    assign sb.pending      = pendingVec;
    assign sb.inflight     = inflight_q;
    assign sb.err          = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard
//
// Drives two scoreboards side by side, one with the writeback bypass and one
// without, from the same stimulus. A behavioural model holding plain integer
// counts per register predicts every output on every cycle. A directed
// sequence walks through the interesting pipeline situations with literal
// expectations, followed by a long randomized run.
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       freeze = 1'b0;
    logic       issueValid = 1'b0;
    logic       issueWbEn = 1'b0;
    logic [3:0] issueDest = '0;
    logic [3:0] src1 = '0;
    logic       src1Valid = 1'b0;
    logic [3:0] src2 = '0;
    logic       twoSrc = 1'b0;
    logic       wbEn = 1'b0;
    logic [3:0] wbDest = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Index 0: scoreboard without bypass, index 1: with bypass.
    reg_scoreboard_if ifBp0 ();
    reg_scoreboard_if ifBp1 ();

    assign ifBp0.freeze      = freeze;
    assign ifBp0.issue_valid = issueValid;
    assign ifBp0.issue_wb_en = issueWbEn;
    assign ifBp0.issue_dest  = issueDest;
    assign ifBp0.src1        = src1;
    assign ifBp0.src1_valid  = src1Valid;
    assign ifBp0.src2        = src2;
    assign ifBp0.two_src     = twoSrc;
    assign ifBp0.wb_en       = wbEn;
    assign ifBp0.wb_dest     = wbDest;

    assign ifBp1.freeze      = freeze;
    assign ifBp1.issue_valid = issueValid;
    assign ifBp1.issue_wb_en = issueWbEn;
    assign ifBp1.issue_dest  = issueDest;
    assign ifBp1.src1        = src1;
    assign ifBp1.src1_valid  = src1Valid;
    assign ifBp1.src2        = src2;
    assign ifBp1.two_src     = twoSrc;
    assign ifBp1.wb_en       = wbEn;
    assign ifBp1.wb_dest     = wbDest;

    reg_scoreboard #(.WB_BYPASS(0)) dutBp0 (
        .clk (clk),
        .rst (rst),
        .sb  (ifBp0.slave)
    );

    reg_scoreboard #(.WB_BYPASS(1)) dutBp1 (
        .clk (clk),
        .rst (rst),
        .sb  (ifBp1.slave)
    );

    logic        hz   [2];
    logic        acc  [2];
    logic [15:0] pend [2];
    logic [3:0]  infl [2];
    logic        er   [2];

    assign hz[0]   = ifBp0.hazard;
    assign hz[1]   = ifBp1.hazard;
    assign acc[0]  = ifBp0.issue_accept;
    assign acc[1]  = ifBp1.issue_accept;
    assign pend[0] = ifBp0.pending;
    assign pend[1] = ifBp1.pending;
    assign infl[0] = ifBp0.inflight;
    assign infl[1] = ifBp1.inflight;
    assign er[0]   = ifBp0.err;
    assign er[1]   = ifBp1.err;

    // Single comparison point: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: outstanding write count per register and sticky error.
    int mcnt [2][16];
    bit merr [2];
    bit started = 1'b0;

    function automatic bit mReady(int b, logic [3:0] r);
        if (mcnt[b][r] == 0) return 1'b1;
        return (b == 1) && (mcnt[b][r] == 1) && wbEn && (wbDest == r);
    endfunction

    function automatic bit mHazard(int b);
        bit raw;
        bit cap;
        raw = (src1Valid && !mReady(b, src1)) || (twoSrc && !mReady(b, src2));
        cap = issueWbEn && (mcnt[b][issueDest] == 3) && !(wbEn && (wbDest == issueDest));
        return issueValid && (raw || cap);
    endfunction

    function automatic bit mAccept(int b);
        return issueValid && !mHazard(b) && !freeze;
    endfunction

    function automatic logic [15:0] mPending(int b);
        logic [15:0] p;
        p = '0;
        for (int r = 0; r < 16; r++) p[r] = (mcnt[b][r] != 0);
        return p;
    endfunction

    function automatic int mInflight(int b);
        int s;
        s = 0;
        for (int r = 0; r < 16; r++) s += mcnt[b][r];
        return s % 16;
    endfunction

    // Every falling edge: compare both DUTs with the model, then advance the
    // model by what the coming rising edge will do.
    always @(negedge clk) begin
        if (started) begin
            for (int b = 0; b < 2; b++) begin
                checkOutput($sformatf("hazard_bp%0d", b),   32'(hz[b]),   32'(mHazard(b)));
                checkOutput($sformatf("accept_bp%0d", b),   32'(acc[b]),  32'(mAccept(b)));
                checkOutput($sformatf("pending_bp%0d", b),  32'(pend[b]), 32'(mPending(b)));
                checkOutput($sformatf("inflight_bp%0d", b), 32'(infl[b]), 32'(mInflight(b)));
                checkOutput($sformatf("err_bp%0d", b),      32'(er[b]),   32'(merr[b]));
            end
        end
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 16; r++) mcnt[b][r] = 0;
                merr[b] = 1'b0;
            end
            started = 1'b1;
        end else if (started) begin
            for (int b = 0; b < 2; b++) begin
                bit a;
                a = mAccept(b);
                for (int r = 0; r < 16; r++) begin
                    bit inc;
                    bit dec;
                    inc = a && issueWbEn && (issueDest == r);
                    dec = wbEn && (wbDest == r);
                    if (dec && mcnt[b][r] == 0) merr[b] = 1'b1;
                    if (inc && !dec) mcnt[b][r]++;
                    else if (dec && !inc && mcnt[b][r] > 0) mcnt[b][r]--;
                end
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge and return at the
    // following falling edge, where the outputs are settled.
    task automatic applyStimulus(input logic r, input logic v, input logic we, input logic [3:0] d,
                                 input logic [3:0] s1, input logic s1v, input logic [3:0] s2,
                                 input logic ts, input logic wbe, input logic [3:0] wbd,
                                 input logic frz);
        @(posedge clk);
        #1;
        rst        = r;
        issueValid = v;
        issueWbEn  = we;
        issueDest  = d;
        src1       = s1;
        src1Valid  = s1v;
        src2       = s2;
        twoSrc     = ts;
        wbEn       = wbe;
        wbDest     = wbd;
        freeze     = frz;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
    endtask

    initial begin
        // Reset then idle.
        applyStimulus(1, 0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
        idleCycle();
        checkOutput("rst_pending", 32'(pend[1]), 32'h0);
        checkOutput("rst_inflight", 32'(infl[1]), 32'h0);
        checkOutput("rst_err", 32'(er[1]), 32'h0);
        checkOutput("rst_hazard", 32'(hz[1]), 32'h0);
        checkOutput("rst_accept", 32'(acc[0]), 32'h0);

        // RAW on R3: bypass releases in the retire cycle, no bypass one later.
        applyStimulus(0, 1, 1, 4'd3, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
        checkOutput("raw_issue_accept", 32'(acc[1]), 32'h1);
        applyStimulus(0, 1, 0, 4'd0, 4'd3, 1, 4'd0, 0, 0, 4'd0, 0);
        checkOutput("raw_stall_bp1", 32'(hz[1]), 32'h1);
        checkOutput("raw_stall_acc_bp0", 32'(acc[0]), 32'h0);
        checkOutput("raw_pending", 32'(pend[1]), 32'h0008);
        applyStimulus(0, 1, 0, 4'd0, 4'd3, 1, 4'd0, 0, 1, 4'd3, 0);
        checkOutput("raw_wb_hazard_bp1", 32'(hz[1]), 32'h0);
        checkOutput("raw_wb_accept_bp1", 32'(acc[1]), 32'h1);
        checkOutput("raw_wb_hazard_bp0", 32'(hz[0]), 32'h1);
        applyStimulus(0, 1, 0, 4'd0, 4'd3, 1, 4'd0, 0, 0, 4'd0, 0);
        checkOutput("raw_late_accept_bp0", 32'(acc[0]), 32'h1);

        // Unused second source must not stall.
        applyStimulus(0, 1, 1, 4'd3, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
        applyStimulus(0, 1, 0, 4'd0, 4'd0, 0, 4'd3, 0, 0, 4'd0, 0);
        checkOutput("unused_src_hazard", 32'(hz[1]), 32'h0);
        applyStimulus(0, 1, 0, 4'd0, 4'd0, 0, 4'd3, 1, 0, 4'd0, 0);
        checkOutput("src2_hazard", 32'(hz[1]), 32'h1);
        applyStimulus(0, 0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 4'd3, 0);

        // Capacity on R5.
        repeat (3) applyStimulus(0, 1, 1, 4'd5, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
        checkOutput("cap_third_accept", 32'(acc[1]), 32'h1);
        idleCycle();
        checkOutput("cap_inflight", 32'(infl[1]), 32'd3);
        checkOutput("cap_pending", 32'(pend[0]), 32'h0020);
        #1;
        checkOutput("model_cap_inflight", 32'(mInflight(1)), 32'd3);
        applyStimulus(0, 1, 1, 4'd5, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
        checkOutput("cap_full_hazard", 32'(hz[1]), 32'h1);
        applyStimulus(0, 1, 1, 4'd5, 4'd0, 0, 4'd0, 0, 1, 4'd5, 0);
        checkOutput("cap_wb_accept", 32'(acc[1]), 32'h1);
        idleCycle();
        checkOutput("cap_wb_inflight", 32'(infl[1]), 32'd3);

        // Simultaneous issue R1 and retire R2, then freeze.
        applyStimulus(0, 1, 1, 4'd2, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
        idleCycle();
        checkOutput("sim_pre_inflight", 32'(infl[1]), 32'd4);
        applyStimulus(0, 1, 1, 4'd1, 4'd0, 0, 4'd0, 0, 1, 4'd2, 0);
        idleCycle();
        checkOutput("sim_pending", 32'(pend[1]), 32'h0022);
        checkOutput("sim_inflight", 32'(infl[1]), 32'd4);
        #1;
        checkOutput("model_sim_pending", 32'(mPending(1)), 32'h0022);
        applyStimulus(0, 1, 1, 4'd1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 1);
        checkOutput("freeze_accept", 32'(acc[1]), 32'h0);
        checkOutput("freeze_hazard", 32'(hz[1]), 32'h0);
        idleCycle();
        checkOutput("freeze_inflight", 32'(infl[1]), 32'd4);

        // Underflow, then reset with writes outstanding and a concurrent issue.
        applyStimulus(0, 0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 4'd7, 0);
        idleCycle();
        checkOutput("uf_err", 32'(er[1]), 32'h1);
        checkOutput("uf_pending", 32'(pend[1]), 32'h0022);
        applyStimulus(1, 1, 1, 4'd9, 4'd0, 0, 4'd0, 0, 1, 4'd1, 0);
        idleCycle();
        checkOutput("mrst_pending", 32'(pend[1]), 32'h0);
        checkOutput("mrst_inflight", 32'(infl[0]), 32'h0);
        checkOutput("mrst_err", 32'(er[1]), 32'h0);

        // Randomized run over a small register window to force collisions.
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic       v;
            logic       we;
            logic       wbe;
            logic       frz;
            logic [3:0] wbd;
            r   = ($urandom_range(99) == 0);
            v   = ($urandom_range(9) < 7);
            we  = ($urandom_range(9) < 7);
            wbe = ($urandom_range(9) < 4);
            frz = ($urandom_range(9) == 0);
            wbd = 4'($urandom_range(5));
            for (int k = 0; k < 8; k++) begin
                if (mcnt[1][wbd] != 0) break;
                wbd = 4'($urandom_range(5));
            end
            applyStimulus(r, v, we, 4'($urandom_range(5)), 4'($urandom_range(5)),
                          1'($urandom_range(1)), 4'($urandom_range(5)),
                          1'($urandom_range(1)), wbe, wbd, frz);
        end

        idleCycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Register-dependency scoreboard and stall controller for the instruction decode stage of the 5-stage ARM pipeline.
- Keeps a per-register count of issued-but-not-retired writes and drives the decode stage's hazard input.
- Decode then zeroes its control outputs and the front end holds fetch/decode.
- Updated on every issue out of decode and every writeback retirement.

Parameters:
NUM_REGS, 16, architectural registers tracked (indexed by 4-bit register numbers)
CNT_W, 2, width of each per-register in-flight counter
MAX_INFLIGHT, 3, maximum outstanding writes per register (must be <= 2^CNT_W - 1)
WB_BYPASS, 1, 1 = a register retiring this cycle with count 1 is treated as ready (register file writes before read)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
freeze  input  1  pipeline frozen (memory stall); no issue is accepted
issue_valid  input  1  decode stage presents an instruction this cycle
issue_wb_en  input  1  presented instruction writes a register (already gated by condition check)
issue_dest  input  4  destination register of presented instruction
src1  input  4  first source register (rn)
src1_valid  input  1  src1 is actually read
src2  input  4  second source register (rm or rd for stores)
two_src  input  1  src2 is actually read
wb_en  input  1  writeback stage retires a register write this cycle
wb_dest  input  4  register being retired
hazard  output  1  stall decode this cycle
issue_accept  output  1  presented instruction is recorded as issued this cycle
pending  output  16  bit i = 1 when count[i] != 0 (registered view)
inflight  output  4  total outstanding writes across all registers
err  output  1  sticky: writeback retired a register whose count was 0

Behaviour:
- Reset (rst=1 at rising edge): all counters = 0, err = 0.
  - Outputs after reset: pending = 0, inflight = 0, hazard = 0, issue_accept = 0.
  - Reset overrides any same-cycle issue or writeback.
- ready(r):
  - True when count[r] == 0.
  - Also true when WB_BYPASS=1, count[r] == 1, wb_en=1 and wb_dest == r.
- RAW stall: raw = (src1_valid & ~ready(src1)) | (two_src & ~ready(src2)).
- WAW/capacity stall: cap = issue_wb_en & (count[issue_dest] == MAX_INFLIGHT) & ~(wb_en & wb_dest == issue_dest).
- hazard = issue_valid & (raw | cap). Combinational, same cycle as inputs; asserted independent of freeze.
- issue_accept = issue_valid & ~hazard & ~freeze.
- Counter update at rising edge, per register r:
  - inc = issue_accept & issue_wb_en & issue_dest == r
  - dec = wb_en & wb_dest == r
  - inc & ~dec: +1. dec & ~inc: -1. Both or neither: unchanged.
- Underflow: dec with count 0 leaves the count at 0 and sets err=1 until reset.
- Overflow is impossible by construction because of cap.
- inflight = registered sum of all counters; it updates in the same edge as the counters.
- pending reflects the counters after the edge (one-cycle latency from issue/wb to pending).
- A stalled instruction is re-presented by decode on following cycles. The scoreboard keeps no memory of it.
- Latency: an issued write to r makes a dependent read stall from the next cycle. The stall releases in the cycle its writeback retires (WB_BYPASS=1) or the cycle after (WB_BYPASS=0).

Test Plan:
- Reset then idle: rst=1 one cycle -> pending=0, inflight=0, err=0, hazard=0 with issue_valid=0.
- RAW: issue dest=R3 accepted; next cycle present src1=R3, src1_valid=1 -> hazard=1, issue_accept=0. Hazard holds until the cycle wb_en=1, wb_dest=3, where hazard=0 and issue_accept=1 (WB_BYPASS=1). Repeat with WB_BYPASS=0 -> accept one cycle later.
- Unused sources: src2=R3 pending but two_src=0, src1_valid=0 -> hazard=0. Then set two_src=1 -> hazard=1.
- Capacity: issue 3 writes to R5 with no writeback -> count=3, inflight=3. A 4th write to R5 -> hazard=1. The same 4th write with a simultaneous wb of R5 -> accepted, count stays 3.
- Simultaneous inc/dec on different regs: issue dest=R1 while wb R2 (count 1) -> pending[1]=1, pending[2]=0, inflight unchanged. Freeze=1 with clean sources -> issue_accept=0, no count change.
- Error and mid-run reset: wb R7 with count 0 -> err=1, count stays 0. Then rst with outstanding writes on R1/R5 and a concurrent issue -> all counts 0, err=0 next cycle.
